// File: rtl/bcd_counter_pkg.sv
// Shared types and elaboration helpers for the BCD up/down counter family.
package bcd_counter_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam int unsigned SYSCLOCK_FREQ = 100_000_000;

   function automatic int unsigned max_count(input int unsigned digits);
      int unsigned m;
      m = 1;
      for (int unsigned i = 0; i < digits; i++) m = m * 10;
      return m - 1;
   endfunction

   function automatic bit width_ok(input int unsigned width, input int unsigned digits);
      return (width >= 32) || ((64'd1 << width) > 64'(max_count(digits)));
   endfunction

endpackage

// File: rtl/debounce_event.sv
// Button synchroniser and debounce timer producing one-cycle events.
// Optional hold-to-repeat is built only when AUTO_REPEAT_EN is defined.
module debounce_event
   import bcd_counter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000,
   parameter bit          REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

   if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > SYSCLOCK_FREQ) begin : g_bad_debounce
      $error("debounce_event: DEBOUNCE_CYCLES out of range");
   end
   if (REPEAT_EN && (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0)) begin : g_bad_repeat
      $error("debounce_event: repeat intervals must be non-zero");
   end

   logic          sync1, sync2, sync3;
   logic          rise;
   logic          debounced;
   logic [DW-1:0] timer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise = sync2 & ~sync3;

   // Every rising edge restarts the window, so bounce only delays the event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              timer <= '0;
      else if (rise)           timer <= DW'(DEBOUNCE_CYCLES);
      else if (timer != '0)    timer <= timer - 1'b1;
   end

   assign debounced = (timer == DW'(1)) && sync2;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rep_timer;
   logic          rep_fire;

   assign rep_fire = REPEAT_EN && (rep_timer == RW'(1)) && sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    rep_timer <= '0;
      else if (!REPEAT_EN || !sync2) rep_timer <= '0;
      else if (debounced)            rep_timer <= RW'(REPEAT_DELAY);
      else if (rep_fire)             rep_timer <= RW'(REPEAT_PERIOD);
      else if (rep_timer != '0)      rep_timer <= rep_timer - 1'b1;
   end

   assign pulse = debounced | rep_fire;
`else
   assign pulse = debounced;
`endif

endmodule

// File: rtl/bcd_updown_counter.sv
// Debounced up/down/clear counter bounded to NUM_DIGITS decimal digits with a
// sequential double-dabble BCD converter. Auto-repeat via AUTO_REPEAT_EN.
module bcd_updown_counter
   import bcd_counter_pkg::*;
#(
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned COUNTER_WIDTH   = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          WRAP            = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      btn_up,
   input  logic                      btn_down,
   input  logic                      btn_clr,
   output logic [COUNTER_WIDTH-1:0]  count,
   output logic [4*NUM_DIGITS-1:0]   bcd,
   output logic                      bcd_valid,
   output logic                      busy,
   output logic                      bound_hit
);

   localparam int unsigned BW = 4 * NUM_DIGITS;
   localparam int unsigned SW = BW + COUNTER_WIDTH;
   localparam int unsigned IW = $clog2(COUNTER_WIDTH + 1);
   localparam logic [COUNTER_WIDTH-1:0] MAX = COUNTER_WIDTH'(max_count(NUM_DIGITS));

   if (!width_ok(COUNTER_WIDTH, NUM_DIGITS)) begin : g_too_narrow
      $error("bcd_updown_counter: COUNTER_WIDTH cannot hold 10**NUM_DIGITS-1");
   end

   logic up_ev, down_ev, clr_ev;
   logic write;

   debounce_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
      u_up   (.clk(clk), .rst_n(rst_n), .btn(btn_up),   .pulse(up_ev));
   debounce_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
      u_down (.clk(clk), .rst_n(rst_n), .btn(btn_down), .pulse(down_ev));
   debounce_event #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
      u_clr  (.clk(clk), .rst_n(rst_n), .btn(btn_clr),  .pulse(clr_ev));

   assign write = clr_ev | (up_ev ^ down_ev);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         bound_hit <= 1'b0;
      end else begin
         bound_hit <= 1'b0;
         if (clr_ev) begin
            count <= '0;
         end else if (up_ev && !down_ev) begin
            if (count == MAX) begin
               count     <= WRAP ? '0 : MAX;
               bound_hit <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end else if (down_ev && !up_ev) begin
            if (count == '0) begin
               count     <= WRAP ? MAX : '0;
               bound_hit <= 1'b1;
            end else begin
               count <= count - 1'b1;
            end
         end
      end
   end

   state_t        state, state_next;
   logic          dirty;
   logic [IW-1:0] iter;
   logic [SW-1:0] shreg, shreg_adj;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (dirty) state_next = S_SHIFT;
         S_SHIFT: if (iter == IW'(COUNTER_WIDTH - 1)) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      shreg_adj = shreg;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
         if (shreg[COUNTER_WIDTH + 4*d +: 4] >= 4'd5)
            shreg_adj[COUNTER_WIDTH + 4*d +: 4] = shreg[COUNTER_WIDTH + 4*d +: 4] + 4'd3;
      end
   end

   // A write in the snapshot cycle keeps dirty set so the newer count is reconverted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirty     <= 1'b0;
         iter      <= '0;
         shreg     <= '0;
         busy      <= 1'b0;
         bcd       <= '0;
         bcd_valid <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         if (write)                          dirty <= 1'b1;
         else if (state == S_IDLE && dirty)  dirty <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (dirty) begin
                  shreg <= SW'(count);
                  iter  <= '0;
                  busy  <= 1'b1;
               end
            end
            S_SHIFT: begin
               shreg <= shreg_adj << 1;
               iter  <= iter + 1'b1;
            end
            S_DONE: begin
               bcd       <= shreg[SW-1 -: BW];
               bcd_valid <= 1'b1;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter: vector table, corner sequences and
// randomized presses against a decimal reference model.
`timescale 1ns/1ps
module tb_bcd_updown_counter;

   localparam int unsigned ND       = 4;
   localparam int unsigned CW       = 16;
   localparam int unsigned DB       = 8;
   localparam int unsigned RD       = 40;
   localparam int unsigned RP       = 10;
   localparam int unsigned MAXC     = 9999;
   localparam int unsigned EV_LAT   = 2 + DB;
   localparam int unsigned CONV_LAT = CW + 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic up = 1'b0, down = 1'b0, clr = 1'b0;
   logic s_up = 1'b0, s_down = 1'b0, s_clr = 1'b0;
   logic [CW-1:0]   count, s_count;
   logic [4*ND-1:0] bcd, s_bcd;
   logic bcd_valid, busy, bound_hit;
   logic s_valid, s_busy, s_bound;

   bcd_updown_counter #(.NUM_DIGITS(ND), .COUNTER_WIDTH(CW), .DEBOUNCE_CYCLES(DB),
                        .WRAP(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
      dut (.clk(clk), .rst_n(rst_n), .btn_up(up), .btn_down(down), .btn_clr(clr),
           .count(count), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy), .bound_hit(bound_hit));

   bcd_updown_counter #(.NUM_DIGITS(ND), .COUNTER_WIDTH(CW), .DEBOUNCE_CYCLES(DB),
                        .WRAP(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
      dut_sat (.clk(clk), .rst_n(rst_n), .btn_up(s_up), .btn_down(s_down), .btn_clr(s_clr),
               .count(s_count), .bcd(s_bcd), .bcd_valid(s_valid), .busy(s_busy), .bound_hit(s_bound));

   always #5 clk = ~clk;

   int unsigned checks = 0, passed = 0;
   int unsigned cyc = 0;
   int unsigned valid_cnt = 0, bound_cnt = 0, s_valid_cnt = 0, s_bound_cnt = 0;
   logic [15:0] prev_bcd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bcd_valid) valid_cnt++;
         if (bound_hit) bound_cnt++;
         if (s_valid)   s_valid_cnt++;
         if (s_bound)   s_bound_cnt++;
         if (bcd !== prev_bcd) check("bcd_changes_only_with_valid", {31'd0, bcd_valid}, 32'd1);
      end
      prev_bcd = bcd;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench exceeded its time budget");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] to_bcd(input int unsigned v);
      logic [15:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int unsigned model_next(input int unsigned cur, input bit u, input bit d,
                                              input bit c, input bit wrap, output bit hit);
      hit = 1'b0;
      if (c) return 0;
      if (u && d) return cur;
      if (u) begin
         if (cur == MAXC) begin hit = 1'b1; return wrap ? 0 : MAXC; end
         return cur + 1;
      end
      if (d) begin
         if (cur == 0) begin hit = 1'b1; return wrap ? MAXC : 0; end
         return cur - 1;
      end
      return cur;
   endfunction

   task automatic press(input logic u, input logic d, input logic c, input int unsigned hold);
      @(negedge clk);
      up = u; down = d; clr = c;
      repeat (hold) @(negedge clk);
      up = 1'b0; down = 1'b0; clr = 1'b0;
   endtask

   task automatic settle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      bit          u, d, c;
      int unsigned exp_count;
      logic [15:0] exp_bcd;
      int unsigned exp_bound;
      int unsigned exp_valid;
   } vec_t;

   vec_t        vecs[13];
   int unsigned m, nm, vb, bb, start, c0, cnt_cyc, val_cyc, exp_rep;
   bit          hit, seen;
   int unsigned r;
   bit          ru, rd, rc;

   initial begin
      vecs[0]  = '{1, 0, 0,    2, 16'h0002, 0, 1};
      vecs[1]  = '{1, 0, 0,    3, 16'h0003, 0, 1};
      vecs[2]  = '{0, 1, 0,    2, 16'h0002, 0, 1};
      vecs[3]  = '{1, 1, 0,    2, 16'h0002, 0, 0};
      vecs[4]  = '{0, 0, 1,    0, 16'h0000, 0, 1};
      vecs[5]  = '{0, 1, 0, 9999, 16'h9999, 1, 1};
      vecs[6]  = '{1, 0, 0,    0, 16'h0000, 1, 1};
      vecs[7]  = '{1, 0, 1,    0, 16'h0000, 0, 1};
      vecs[8]  = '{0, 1, 0, 9999, 16'h9999, 1, 1};
      vecs[9]  = '{0, 1, 0, 9998, 16'h9998, 0, 1};
      vecs[10] = '{1, 0, 0, 9999, 16'h9999, 0, 1};
      vecs[11] = '{1, 0, 0,    0, 16'h0000, 1, 1};
      vecs[12] = '{0, 0, 1,    0, 16'h0000, 0, 1};

      // reset state
      settle(3);
      check("reset_count", 32'(count), 0);
      check("reset_bcd", 32'(bcd), 0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_valid", {31'd0, bcd_valid}, 0);
      check("reset_bound", {31'd0, bound_hit}, 0);
      rst_n = 1'b1;
      settle(3);

      // first press latency from raw edge
      cnt_cyc = 0; val_cyc = 0;
      @(negedge clk);
      up = 1'b1;
      c0 = cyc;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 10) up = 1'b0;
         if (cnt_cyc == 0 && count == 16'd1) cnt_cyc = cyc;
         if (val_cyc == 0 && bcd_valid) val_cyc = cyc;
      end
      check("count_update_cycle", cnt_cyc - c0, EV_LAT + 1);
      check("bcd_valid_latency", val_cyc - c0, EV_LAT + CONV_LAT);
      check("first_bcd", 32'(bcd), 32'h0001);
      m = 1;

      // vector table
      for (int i = 0; i < 13; i++) begin
         vb = valid_cnt; bb = bound_cnt;
         press(vecs[i].u, vecs[i].d, vecs[i].c, 10);
         settle(45);
         check($sformatf("vec%0d_count", i), 32'(count), vecs[i].exp_count);
         check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
         check($sformatf("vec%0d_bound", i), bound_cnt - bb, vecs[i].exp_bound);
         check($sformatf("vec%0d_valid", i), valid_cnt - vb, vecs[i].exp_valid);
      end
      m = 0;

      // bounce: glitches of 3 cycles, then held 20 cycles
      vb = valid_cnt;
      @(negedge clk);
      for (int g = 0; g < 6; g++) begin
         up = (g % 2 == 0);
         repeat (3) @(negedge clk);
      end
      up = 1'b1;
      repeat (20) @(negedge clk);
      up = 1'b0;
      settle(45);
      m = m + 1;
      check("bounce_count", 32'(count), m);
      check("bounce_valid", valid_cnt - vb, 1);

      // short pulse is rejected
      vb = valid_cnt;
      press(1, 0, 0, 5);
      settle(40);
      check("short_pulse_count", 32'(count), m);
      check("short_pulse_valid", valid_cnt - vb, 0);

      // four events overlapping conversions coalesce into three conversions
      vb = valid_cnt; start = m;
      for (int k = 0; k < 4; k++) press(1, 0, 0, 10);
      settle(60);
      m = start + 4;
      check("coalesce_count", 32'(count), m);
      check("coalesce_bcd", 32'(bcd), 32'(to_bcd(m)));
      check("coalesce_conversions", valid_cnt - vb, 3);

      // long hold
`ifdef AUTO_REPEAT_EN
      exp_rep = 1 + 1 + (100 - RD) / RP;
`else
      exp_rep = 1;
`endif
      start = m;
      press(1, 0, 0, 115);
      settle(60);
      m = start + exp_rep;
      check("hold_count", 32'(count), m);
      check("hold_bcd", 32'(bcd), 32'(to_bcd(m)));

      // randomized presses against the model
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 99);
         ru = (r < 45) || (r >= 94) || (r >= 88 && r < 94);
         rd = (r >= 45 && r < 80) || (r >= 88 && r < 94);
         rc = (r >= 80 && r < 88) || (r >= 94);
         vb = valid_cnt; bb = bound_cnt;
         nm = model_next(m, ru, rd, rc, 1'b1, hit);
         press(ru, rd, rc, 10);
         settle(45);
         check($sformatf("rand%0d_count", i), 32'(count), nm);
         check($sformatf("rand%0d_bcd", i), 32'(bcd), 32'(to_bcd(nm)));
         check($sformatf("rand%0d_bound", i), bound_cnt - bb, {31'd0, hit});
         check($sformatf("rand%0d_valid", i), valid_cnt - vb, (rc || (ru ^ rd)) ? 1 : 0);
         m = nm;
      end

      // saturating instance: down at zero
      vb = s_valid_cnt; bb = s_bound_cnt;
      @(negedge clk);
      s_down = 1'b1;
      repeat (10) @(negedge clk);
      s_down = 1'b0;
      settle(45);
      check("sat_count", 32'(s_count), 0);
      check("sat_bcd", 32'(s_bcd), 0);
      check("sat_bound", s_bound_cnt - bb, 1);
      check("sat_valid", s_valid_cnt - vb, 1);

      // reset in the middle of a conversion
      press(1, 0, 0, 10);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      check("busy_seen", {31'd0, seen}, 1);
      repeat (5) @(negedge clk);
      vb = valid_cnt;
      rst_n = 1'b0;
      #1;
      check("midreset_count", 32'(count), 0);
      check("midreset_bcd", 32'(bcd), 0);
      check("midreset_busy", {31'd0, busy}, 0);
      check("midreset_valid", {31'd0, bcd_valid}, 0);
      check("midreset_bound", {31'd0, bound_hit}, 0);
      settle(3);
      rst_n = 1'b1;
      settle(40);
      check("midreset_no_valid", valid_cnt - vb, 0);
      check("midreset_bcd_after", 32'(bcd), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
